// File: rtl/board_ram_arbiter_if.sv
// board_ram_arbiter_if: requester-side bus of the board RAM arbiter.
interface board_ram_arbiter_if #(parameter int N = 4);
   logic [N-1:0]   req;
   logic [N-1:0]   acc;
   logic [N-1:0]   wren_in;
   logic [8*N-1:0] addr_in;
   logic [6*N-1:0] wdata_in;
   logic [N-1:0]   grant;
   logic [N-1:0]   rvalid;
   logic [5:0]     rdata;
   logic           busy;
   modport master (output req, acc, wren_in, addr_in, wdata_in, input grant, rvalid, rdata, busy);
   modport slave  (input req, acc, wren_in, addr_in, wdata_in, output grant, rvalid, rdata, busy);
endinterface

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: round-robin burst arbiter sharing the single-port board RAM between N
// requesters, with forced release after MAX_HOLD cycles and tagged read-data return.
module board_ram_arbiter #(
   parameter int N          = 4,
   parameter int RD_LATENCY = 1,
   parameter int MAX_HOLD   = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   board_ram_arbiter_if.slave  bus,
   output logic [7:0]          o_ram_addr,
   output logic [5:0]          o_ram_data,
   output logic                o_ram_wren,
   input  logic [5:0]          i_ram_q
);
   localparam int IW = $clog2(N);
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   typedef enum logic [1:0] {IDLE, OWN, HANDOFF} state_t;
   state_t                   r_state, w_next;
   logic [IW-1:0]            r_owner, r_last, w_winner;
   logic [HW-1:0]            r_hold;
   logic [N-1:0]             w_grant;
   logic                     w_force, w_acc, w_wr;
   logic [7:0]               r_ram_addr;
   logic [5:0]               r_ram_data;
   logic                     r_ram_wren;
   logic [RD_LATENCY:0][N-1:0] r_tag;
   // Descending scan so the requester nearest to last+1 is assigned last and wins.
   always_comb begin
      w_winner = r_last;
      for (int k = N; k >= 1; k--)
         if (bus.req[IW'((int'(r_last) + k) % N)]) w_winner = IW'((int'(r_last) + k) % N);
   end
   always_comb begin
      w_force = (MAX_HOLD > 0) && (r_hold == HW'(MAX_HOLD - 1)) && |(bus.req & ~w_grant);
      w_next  = (r_state == IDLE) ? (|bus.req ? OWN : IDLE) :
                (r_state == OWN)  ? ((!bus.req[r_owner] || w_force) ? HANDOFF : OWN) : IDLE;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_last  <= IW'(N - 1);
         r_hold  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && |bus.req) begin
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_hold  <= '0;
         end else if (r_state == OWN && r_hold != HW'(MAX_HOLD - 1)) begin
            r_hold  <= r_hold + 1'b1;
         end
      end
   end
   always_comb begin
      w_grant    = (r_state == OWN) ? (N'(1) << r_owner) : '0;
      w_acc      = |(w_grant & bus.acc);
      w_wr       = bus.wren_in[r_owner];
      bus.grant  = w_grant;
      bus.rvalid = r_tag[RD_LATENCY];
      bus.rdata  = i_ram_q;
      bus.busy   = |w_grant || |r_tag;
      o_ram_addr = r_ram_addr;
      o_ram_data = r_ram_data;
      o_ram_wren = r_ram_wren;
   end
   // Read tags follow the RAM pipeline so returns still reach their issuer after grant moves.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ram_addr <= '0;
         r_ram_data <= '0;
         r_ram_wren <= 1'b0;
         r_tag      <= '0;
      end else begin
         r_ram_wren <= w_acc & w_wr;
         r_tag      <= {r_tag[RD_LATENCY-1:0], (w_acc && !w_wr) ? w_grant : N'(0)};
         if (w_acc) begin
            r_ram_addr <= bus.addr_in[r_owner*8 +: 8];
            r_ram_data <= bus.wdata_in[r_owner*6 +: 6];
         end
      end
   end
endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter: directed vector table, multi-cycle corner sequences and a randomized
// run against a transaction-level reference model of the arbiter.
module tb_board_ram_arbiter;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] ram_addr;
   logic [5:0] ram_data, ram_q;
   logic       ram_wren;
   logic [5:0] mem [256];
   logic [5:0] shadow [256];
   int         n_vec = 0, n_err = 0;

   board_ram_arbiter_if #(.N(4)) bus ();
   board_ram_arbiter #(.N(4), .RD_LATENCY(1), .MAX_HOLD(4)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_ram_wren(ram_wren), .i_ram_q(ram_q));

   always #5 clk = ~clk;
   // Single-port RAM with one cycle of read latency, read-old-data on same-cycle write
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   typedef struct {
      logic [3:0] req, acc, wren;
      logic [7:0] addr;
      logic [5:0] wdata;
      logic [3:0] e_grant, e_rvalid;
      logic [5:0] e_rdata;
      logic       e_wren;
   } vec_t;
   typedef struct { int due; int id; logic [5:0] data; } rd_t;
   vec_t tv [17];
   rd_t  rq [$];

   function automatic vec_t mk(logic [3:0] rq_, ac, wr, logic [7:0] ad, logic [5:0] wd,
                               logic [3:0] g, rv, logic [5:0] rd, logic we);
      vec_t v;
      v.req = rq_; v.acc = ac; v.wren = wr; v.addr = ad; v.wdata = wd;
      v.e_grant = g; v.e_rvalid = rv; v.e_rdata = rd; v.e_wren = we;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(logic [3:0] r, a, w, logic [7:0] ad, logic [5:0] wd);
      bus.req = r; bus.acc = a; bus.wren_in = w;
      bus.addr_in = {4{ad}}; bus.wdata_in = {4{wd}};
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(4'h0, 4'h0, 4'h0, 8'd0, 6'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Reference model state
   int         m_owner, m_last, m_held, cyc;
   bit         m_gap;
   logic       e_wren;
   logic [7:0] e_addr;
   logic [5:0] e_data;

   task automatic model_step();
      logic [7:0] a;
      logic [5:0] d;
      e_wren = 1'b0;
      if (m_owner >= 0 && bus.acc[m_owner]) begin
         a = bus.addr_in[m_owner*8 +: 8];
         d = bus.wdata_in[m_owner*6 +: 6];
         e_addr = a;
         e_data = d;
         if (bus.wren_in[m_owner]) begin
            shadow[a] = d;
            e_wren = 1'b1;
         end else begin
            rq.push_back('{cyc + 2, m_owner, shadow[a]});
         end
      end
      if (m_owner >= 0) begin
         m_held++;
         if (!bus.req[m_owner] || (m_held >= 4 && (bus.req & ~(4'b1 << m_owner)) != 4'h0)) begin
            m_owner = -1;
            m_gap = 1'b1;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (bus.req != 4'h0) begin
         for (int k = 1; k <= 4 && m_owner < 0; k++)
            if (bus.req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
         m_last = m_owner;
         m_held = 0;
      end
      cyc++;
   endtask

   initial begin
      logic [3:0]  g4 [11] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h1};
      logic [3:0]  rr, eg, erv;
      logic [31:0] ad32;
      logic [23:0] wd24;
      logic        have_rv;
      logic [5:0]  erd;
      for (int i = 0; i < 256; i++) mem[i] = 6'(i);
      mem[37] = 6'h2A;
      tv[0]  = mk(4'hF, 4'h0, 4'h0, 8'd0,   6'h00, 4'h1, 4'h0, 6'h00, 1'b0);
      tv[1]  = mk(4'hF, 4'h1, 4'h1, 8'd200, 6'h15, 4'h1, 4'h0, 6'h00, 1'b1);
      tv[2]  = mk(4'hF, 4'h1, 4'h0, 8'd200, 6'h00, 4'h1, 4'h0, 6'h00, 1'b0);
      tv[3]  = mk(4'hE, 4'h0, 4'h0, 8'd0,   6'h00, 4'h0, 4'h1, 6'h15, 1'b0);
      tv[4]  = mk(4'hE, 4'h0, 4'h0, 8'd0,   6'h00, 4'h0, 4'h0, 6'h00, 1'b0);
      tv[5]  = mk(4'hE, 4'h0, 4'h0, 8'd0,   6'h00, 4'h2, 4'h0, 6'h00, 1'b0);
      tv[6]  = mk(4'hC, 4'h0, 4'h0, 8'd0,   6'h00, 4'h0, 4'h0, 6'h00, 1'b0);
      tv[7]  = mk(4'hC, 4'h0, 4'h0, 8'd0,   6'h00, 4'h0, 4'h0, 6'h00, 1'b0);
      tv[8]  = mk(4'hC, 4'h0, 4'h0, 8'd0,   6'h00, 4'h4, 4'h0, 6'h00, 1'b0);
      tv[9]  = mk(4'hC, 4'h4, 4'h0, 8'd37,  6'h00, 4'h4, 4'h0, 6'h00, 1'b0);
      tv[10] = mk(4'hC, 4'h0, 4'h0, 8'd0,   6'h00, 4'h4, 4'h4, 6'h2A, 1'b0);
      tv[11] = mk(4'h8, 4'h1, 4'h1, 8'd37,  6'h3F, 4'h0, 4'h0, 6'h00, 1'b0);
      tv[12] = mk(4'h8, 4'h0, 4'h0, 8'd0,   6'h00, 4'h0, 4'h0, 6'h00, 1'b0);
      tv[13] = mk(4'h8, 4'h0, 4'h0, 8'd0,   6'h00, 4'h8, 4'h0, 6'h00, 1'b0);
      tv[14] = mk(4'h0, 4'h0, 4'h0, 8'd0,   6'h00, 4'h0, 4'h0, 6'h00, 1'b0);
      tv[15] = mk(4'h0, 4'h0, 4'h0, 8'd0,   6'h00, 4'h0, 4'h0, 6'h00, 1'b0);
      tv[16] = mk(4'h0, 4'h0, 4'h0, 8'd0,   6'h00, 4'h0, 4'h0, 6'h00, 1'b0);
      do_reset();
      chk("reset_grant", 32'(bus.grant), 0);
      chk("reset_busy", 32'(bus.busy), 0);
      for (int v = 0; v < 17; v++) begin
         drive(tv[v].req, tv[v].acc, tv[v].wren, tv[v].addr, tv[v].wdata);
         @(negedge clk);
         chk($sformatf("tv%0d_grant", v), 32'(bus.grant), 32'(tv[v].e_grant));
         chk($sformatf("tv%0d_rvalid", v), 32'(bus.rvalid), 32'(tv[v].e_rvalid));
         chk($sformatf("tv%0d_wren", v), 32'(ram_wren), 32'(tv[v].e_wren));
         if (tv[v].e_rvalid != 4'h0) chk($sformatf("tv%0d_rdata", v), 32'(bus.rdata), 32'(tv[v].e_rdata));
      end
      // Forced release after 4 grant cycles, then back to the preempted owner
      do_reset();
      drive(4'h1, 4'h0, 4'h0, 8'd0, 6'd0);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         chk($sformatf("hold_grant%0d", i), 32'(bus.grant), 32'(g4[i]));
         if (i == 0) drive(4'h3, 4'h0, 4'h0, 8'd0, 6'd0);
         if (i == 7) drive(4'h1, 4'h0, 4'h0, 8'd0, 6'd0);
      end
      // Read issued in the cycle req drops still returns to its issuer
      do_reset();
      drive(4'hA, 4'h0, 4'h0, 8'd0, 6'd0);
      @(negedge clk);
      chk("drop_grant_a", 32'(bus.grant), 32'h2);
      drive(4'h8, 4'h2, 4'h0, 8'd37, 6'd0);
      @(negedge clk);
      chk("drop_grant_b", 32'(bus.grant), 0);
      chk("drop_rvalid_b", 32'(bus.rvalid), 0);
      drive(4'h8, 4'h0, 4'h0, 8'd0, 6'd0);
      @(negedge clk);
      chk("drop_rvalid_c", 32'(bus.rvalid), 32'h2);
      chk("drop_rdata_c", 32'(bus.rdata), 32'h2A);
      @(negedge clk);
      chk("drop_grant_d", 32'(bus.grant), 32'h8);
      // Asynchronous reset with a read in flight
      do_reset();
      drive(4'h4, 4'h0, 4'h0, 8'd0, 6'd0);
      @(negedge clk);
      chk("arst_grant_pre", 32'(bus.grant), 32'h4);
      drive(4'h4, 4'h4, 4'h0, 8'd37, 6'h11);
      @(negedge clk);
      chk("arst_busy_pre", 32'(bus.busy), 1);
      chk("arst_addr_pre", 32'(ram_addr), 37);
      drive(4'h4, 4'h0, 4'h0, 8'd0, 6'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_grant", 32'(bus.grant), 0);
      chk("arst_rvalid", 32'(bus.rvalid), 0);
      chk("arst_wren", 32'(ram_wren), 0);
      chk("arst_addr", 32'(ram_addr), 0);
      chk("arst_data", 32'(ram_data), 0);
      chk("arst_busy", 32'(bus.busy), 0);
      drive(4'hA, 4'h0, 4'h0, 8'd0, 6'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("arst_post_rvalid%0d", i), 32'(bus.rvalid), 0);
         chk($sformatf("arst_post_grant%0d", i), 32'(bus.grant), 32'h2);
      end
      // Randomized traffic against the reference model
      do_reset();
      shadow = mem;
      m_owner = -1; m_last = 3; m_held = 0; m_gap = 1'b0; cyc = 0;
      e_wren = 1'b0; e_addr = 8'd0; e_data = 6'd0;
      rr = 4'h0;
      rq.delete();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         eg = (m_owner >= 0) ? 4'(4'b1 << m_owner) : 4'h0;
         chk("rnd_busy", 32'(bus.busy), 32'(eg != 4'h0 || rq.size() != 0));
         have_rv = rq.size() != 0 && rq[0].due == cyc;
         erv = 4'h0;
         erd = 6'h0;
         if (have_rv) begin
            erv = 4'(4'b1 << rq[0].id);
            erd = rq[0].data;
            void'(rq.pop_front());
         end
         chk("rnd_grant", 32'(bus.grant), 32'(eg));
         chk("rnd_rvalid", 32'(bus.rvalid), 32'(erv));
         if (have_rv) chk("rnd_rdata", 32'(bus.rdata), 32'(erd));
         chk("rnd_wren", 32'(ram_wren), 32'(e_wren));
         chk("rnd_addr", 32'(ram_addr), 32'(e_addr));
         chk("rnd_data", 32'(ram_data), 32'(e_data));
         for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) rr[i] = ~rr[i];
         for (int i = 0; i < 4; i++) ad32[i*8 +: 8] = 8'($urandom_range(15));
         wd24 = 24'($urandom);
         bus.req = rr;
         bus.acc = 4'($urandom);
         bus.wren_in = 4'($urandom);
         bus.addr_in = ad32;
         bus.wdata_in = wd24;
         model_step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
